// File: rtl/cond_logic.sv
// cond_logic: ARMv4 condition evaluation, NZCV flag register and write-strobe gating.
module cond_logic #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);
  logic n, z, c, v, base;
  assign {n, z, c, v} = Flags;
  // Odd codes are the negation of the even code below them; 1111 is the squashing inverse of AL.
  always_comb begin
    case (Cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & !z;
      3'd5:    base = n == v;
      3'd6:    base = !z & (n == v);
      default: base = 1'b1;
    endcase
    CondEx = base ^ Cond[0];
  end
  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & !NoWrite;
  assign MemWrite = MemW & CondEx;
  always_ff @(posedge clk) begin
    if (reset) Flags <= FLAGS_RESET;
    else begin
      if (FlagW[1] & CondEx) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] & CondEx) Flags[1:0] <= ALUFlags[1:0];
    end
  end
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: table-driven vectors, exhaustive condition sweep and reset-over-write check.
module tb_cond_logic;
  logic clk = 1'b0;
  logic reset, PCS, RegW, MemW, NoWrite;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;
  int errors = 0;
  int checks = 0;

  typedef struct {
    string name;
    logic rst;
    logic [3:0] cond, alu;
    logic [1:0] fw;
    logic pcs, regw, memw, nw;
    logic [3:0] outs, flags;
  } vec_t;
  typedef struct {
    string name;
    logic [3:0] outs, flags;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  cond_logic dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic r, logic [3:0] c, logic [3:0] a, logic [1:0] fw,
                              logic p, logic rw, logic mw, logic nw, logic [3:0] o, logic [3:0] f);
    vec_t t;
    t.name = n; t.rst = r; t.cond = c; t.alu = a; t.fw = fw;
    t.pcs = p; t.regw = rw; t.memw = mw; t.nw = nw; t.outs = o; t.flags = f;
    return t;
  endfunction

  function automatic logic ref_cond(logic [3:0] c, logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (c)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fn;
      4'h5: return !fn;
      4'h6: return fv;
      4'h7: return !fv;
      4'h8: return fc && !fz;
      4'h9: return !fc || fz;
      4'hA: return fn == fv;
      4'hB: return fn != fv;
      4'hC: return !fz && (fn == fv);
      4'hD: return fz || (fn != fv);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void chk(string n, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endfunction

  // Drive at negedge; outputs {CondEx,PCSrc,RegWrite,MemWrite} checked mid-cycle, Flags after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    reset = v.rst; Cond = v.cond; ALUFlags = v.alu; FlagW = v.fw;
    PCS = v.pcs; RegW = v.regw; MemW = v.memw; NoWrite = v.nw;
    e.name = v.name; e.outs = v.outs; e.flags = v.flags;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    chk({e.name, " outs"}, {CondEx, PCSrc, RegWrite, MemWrite}, e.outs);
    @(posedge clk);
    #1;
    chk({e.name, " flags"}, Flags, e.flags);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic ce, rw, mw, nw;
    reset = 1'b1; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    @(posedge clk);
    @(negedge clk);
    //                 name          rst cond   alu    fw     pcs rw mw nw outs   flags
    vecs.push_back(mk("reset_eq",   0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 4'b0000, 4'b0000));
    vecs.push_back(mk("reset_al",   0, 4'hE, 4'h0, 2'b00, 1, 1, 1, 0, 4'b1111, 4'b0000));
    vecs.push_back(mk("cmp",        0, 4'hE, 4'h6, 2'b11, 0, 1, 0, 1, 4'b1000, 4'b0110));
    vecs.push_back(mk("beq",        0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0, 4'b1100, 4'b0110));
    vecs.push_back(mk("load_f",     0, 4'hE, 4'hF, 2'b11, 0, 1, 0, 0, 4'b1010, 4'b1111));
    vecs.push_back(mk("part_nz",    0, 4'hE, 4'h0, 2'b10, 0, 0, 0, 0, 4'b1000, 4'b0011));
    vecs.push_back(mk("part_cv",    0, 4'hE, 4'h0, 2'b01, 0, 0, 0, 0, 4'b1000, 4'b0000));
    vecs.push_back(mk("ne_pass",    0, 4'h1, 4'h0, 2'b00, 0, 1, 0, 0, 4'b1010, 4'b0000));
    vecs.push_back(mk("squash",     0, 4'h0, 4'hF, 2'b11, 0, 1, 1, 0, 4'b0000, 4'b0000));
    vecs.push_back(mk("load_8",     0, 4'hE, 4'h8, 2'b11, 0, 0, 0, 0, 4'b1000, 4'b1000));
    vecs.push_back(mk("ge_8",       0, 4'hA, 4'h0, 2'b00, 1, 0, 0, 0, 4'b0000, 4'b1000));
    vecs.push_back(mk("lt_8",       0, 4'hB, 4'h0, 2'b00, 1, 0, 0, 0, 4'b1100, 4'b1000));
    vecs.push_back(mk("gt_8",       0, 4'hC, 4'h0, 2'b00, 1, 0, 0, 0, 4'b0000, 4'b1000));
    vecs.push_back(mk("le_8_set9",  0, 4'hD, 4'h9, 2'b11, 1, 0, 0, 0, 4'b1100, 4'b1001));
    vecs.push_back(mk("ge_9",       0, 4'hA, 4'h0, 2'b00, 1, 0, 0, 0, 4'b1100, 4'b1001));
    vecs.push_back(mk("gt_9_set4",  0, 4'hC, 4'h4, 2'b11, 1, 0, 0, 0, 4'b1100, 4'b0100));
    vecs.push_back(mk("gt_4",       0, 4'hC, 4'h0, 2'b00, 1, 0, 0, 0, 4'b0000, 4'b0100));
    vecs.push_back(mk("le_4",       0, 4'hD, 4'h0, 2'b00, 1, 0, 0, 0, 4'b1100, 4'b0100));
    vecs.push_back(mk("nv_squash",  0, 4'hF, 4'hF, 2'b11, 1, 1, 1, 0, 4'b0000, 4'b0100));
    vecs.push_back(mk("rst_vs_fw",  1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 4'b1000, 4'b0000));
    vecs.push_back(mk("post_rst",   0, 4'hE, 4'h0, 2'b00, 1, 1, 1, 0, 4'b1111, 4'b0000));
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    for (int f = 0; f < 16; f++) begin
      step(mk($sformatf("sweep_load_%0d", f), 0, 4'hE, f[3:0], 2'b11, 0, 0, 0, 0, 4'b1000, f[3:0]));
      for (int c = 0; c < 16; c++) begin
        ce = ref_cond(c[3:0], f[3:0]);
        rw = c[0]; mw = c[1]; nw = c[2];
        step(mk($sformatf("sweep_c%0d_f%0d", c, f), 0, c[3:0], 4'h0, 2'b00, 1, rw, mw, nw,
                {ce, ce, rw & ce & !nw, mw & ce}, f[3:0]));
      end
    end
    step(mk("final_rst", 1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 4'b1000, 4'b0000));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
